// File: rtl/countdn_mmss.sv
// BCD minutes:seconds countdown timer with run/pause control, a reload
// shadow register for restarting an expired countdown, and a one-cycle
// terminal-count pulse. Time only advances on single-cycle ce ticks.
module countdn_mmss #(
  parameter int MAX_MIN = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       ld,
  input  logic [7:0] d_min,
  input  logic [7:0] d_sec,
  input  logic       start,
  input  logic       pause,
  output logic [7:0] min_q,
  output logic [7:0] sec_q,
  output logic       running,
  output logic       expired,
  output logic       tc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] MaxTens = 4'(MAX_MIN / 10);
  localparam logic [3:0] MaxOnes = 4'(MAX_MIN % 10);

  state_t      state_q, state_d;
  logic [7:0]  min_d, sec_d;
  logic [15:0] reload_q, reload_d;
  logic        tc_d;
  logic [15:0] count;
  logic [15:0] countDec;
  logic [15:0] loadVal;

  // Limit a single BCD digit to an upper bound.
  function automatic logic [3:0] clampDigit(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  // Sanitise a loaded value: fix illegal digits first, then cap the minutes.
  function automatic logic [15:0] clampLoad(input logic [7:0] dm, input logic [7:0] ds);
    logic [3:0] mt, mo, st, so;
    logic [7:0] minVal;
    st = clampDigit(ds[7:4], 4'd5);
    so = clampDigit(ds[3:0], 4'd9);
    mt = dm[7:4];
    mo = clampDigit(dm[3:0], 4'd9);
    minVal = ({4'd0, mt} * 8'd10) + {4'd0, mo};
    if (minVal > 8'(MAX_MIN)) begin
      mt = MaxTens;
      mo = MaxOnes;
    end
    return {mt, mo, st, so};
  endfunction

  // One-second BCD decrement; the borrow ripples from seconds ones upward.
  // Never called on 00:00, so the minutes tens digit cannot underflow.
  function automatic logic [15:0] decrement(input logic [15:0] v);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = v;
    if (so == 4'd0) begin
      so = 4'd9;
      if (st == 4'd0) begin
        st = 4'd5;
        if (mo == 4'd0) begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end else begin
          mo = mo - 4'd1;
        end
      end else begin
        st = st - 4'd1;
      end
    end else begin
      so = so - 4'd1;
    end
    return {mt, mo, st, so};
  endfunction

  assign count    = {min_q, sec_q};
  assign countDec = decrement(count);
  assign loadVal  = clampLoad(d_min, d_sec);

  // Next-state and next-count selection: load beats start/pause, which beat ce.
  always_comb begin
    state_d  = state_q;
    min_d    = min_q;
    sec_d    = sec_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (ld) begin
      {min_d, sec_d} = loadVal;
      reload_d       = loadVal;
      state_d        = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (count != 16'h0000) begin
              state_d = RUN;
            end else begin
              state_d = DONE;
              tc_d    = 1'b1;
            end
          end
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSE;
          end else if (ce) begin
            {min_d, sec_d} = countDec;
            if (countDec == 16'h0000) begin
              state_d = DONE;
              tc_d    = 1'b1;
            end
          end
        end
        PAUSE: begin
          if (start) begin
            state_d = RUN;
          end
        end
        DONE: begin
          if (start) begin
            {min_d, sec_d} = reload_q;
            if (reload_q != 16'h0000) begin
              state_d = RUN;
            end else begin
              tc_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, count and registered status outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      min_q    <= 8'h00;
      sec_q    <= 8'h00;
      reload_q <= 16'h0000;
      running  <= 1'b0;
      expired  <= 1'b0;
      tc       <= 1'b0;
    end else begin
      state_q  <= state_d;
      min_q    <= min_d;
      sec_q    <= sec_d;
      reload_q <= reload_d;
      running  <= (state_d == RUN);
      expired  <= (state_d == DONE);
      tc       <= tc_d;
    end
  end

endmodule

// File: tb/tb_countdn_mmss.sv
// Self-checking bench for countdn_mmss: directed scenarios followed by
// randomized traffic, all compared against a seconds-based reference model.
module tb_countdn_mmss;

  logic       clk;
  logic       rst;
  logic       ce;
  logic       ld;
  logic [7:0] d_min;
  logic [7:0] d_sec;
  logic       start;
  logic       pause;
  logic [7:0] min_q;
  logic [7:0] sec_q;
  logic       running;
  logic       expired;
  logic       tc;

  int checkCount = 0;
  int errCount   = 0;
  int cycleNum   = 0;
  int tcSeen     = 0;

  // Reference model: remaining time kept as plain seconds.
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;
  int mRem    = 0;
  int mReload = 0;
  int mMode   = M_IDLE;
  bit mTc     = 1'b0;

  countdn_mmss #(.MAX_MIN(59)) dut (
    .clk    (clk),
    .rst    (rst),
    .ce     (ce),
    .ld     (ld),
    .d_min  (d_min),
    .d_sec  (d_sec),
    .start  (start),
    .pause  (pause),
    .min_q  (min_q),
    .sec_q  (sec_q),
    .running(running),
    .expired(expired),
    .tc     (tc)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s cycle=%0d got=%h expected=%h", tag, cycleNum, obs, exp);
    end
  endtask

  function automatic int clampSeconds(input logic [7:0] dm, input logic [7:0] ds);
    int mt, mo, st, so, mins;
    st = (int'(ds[7:4]) > 5) ? 5 : int'(ds[7:4]);
    so = (int'(ds[3:0]) > 9) ? 9 : int'(ds[3:0]);
    mt = int'(dm[7:4]);
    mo = (int'(dm[3:0]) > 9) ? 9 : int'(dm[3:0]);
    mins = mt * 10 + mo;
    if (mins > 59) mins = 59;
    return mins * 60 + st * 10 + so;
  endfunction

  function automatic logic [7:0] toBcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic applyStimulus(input bit r, input bit l, input logic [7:0] dm, input logic [7:0] ds,
                               input bit s, input bit p, input bit c);
    @(negedge clk);
    rst = r; ld = l; d_min = dm; d_sec = ds; start = s; pause = p; ce = c;
    mTc = 1'b0;
    if (r) begin
      mRem = 0; mReload = 0; mMode = M_IDLE;
    end else if (l) begin
      mReload = clampSeconds(dm, ds);
      mRem    = mReload;
      mMode   = M_IDLE;
    end else begin
      case (mMode)
        M_IDLE: if (s) begin
          if (mRem > 0) mMode = M_RUN;
          else begin mMode = M_DONE; mTc = 1'b1; end
        end
        M_RUN: if (p) mMode = M_PAUSE;
               else if (c) begin
                 mRem = mRem - 1;
                 if (mRem == 0) begin mMode = M_DONE; mTc = 1'b1; end
               end
        M_PAUSE: if (s) mMode = M_RUN;
        default: if (s) begin
          mRem = mReload;
          if (mRem > 0) mMode = M_RUN;
          else mTc = 1'b1;
        end
      endcase
    end
    @(posedge clk);
    #1;
    cycleNum++;
    if (tc === 1'b1) tcSeen++;
    checkOutput("min", {8'h00, min_q}, {8'h00, toBcd(mRem / 60)});
    checkOutput("sec", {8'h00, sec_q}, {8'h00, toBcd(mRem % 60)});
    checkOutput("running", {15'd0, running}, {15'd0, mMode == M_RUN});
    checkOutput("expired", {15'd0, expired}, {15'd0, mMode == M_DONE});
    checkOutput("tc", {15'd0, tc}, {15'd0, mTc});
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 0);
  endtask

  initial begin
    int tcBase;
    logic [7:0] rdm, rds;
    logic [31:0] rnd;
    rst = 1'b1; ld = 1'b0; ce = 1'b0; start = 1'b0; pause = 1'b0;
    d_min = 8'h00; d_sec = 8'h00;

    // Reset overrides a simultaneous load, start and tick.
    applyStimulus(1, 1, 8'h12, 8'h34, 1, 0, 1);
    checkOutput("rstCount", {min_q, sec_q}, 16'h0000);
    checkOutput("rstFlags", {13'd0, running, expired, tc}, 16'h0000);

    // 01:02 countdown to expiry with ticks five cycles apart.
    applyStimulus(0, 1, 8'h01, 8'h02, 0, 0, 0);
    checkOutput("ld0102", {min_q, sec_q}, 16'h0102);
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 0, 0);
    tcBase = tcSeen;
    for (int t = 1; t <= 62; t++) begin
      applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 1);
      if (t == 3) checkOutput("borrow0059", {min_q, sec_q}, 16'h0059);
      if (t == 62) checkOutput("tcLastTick", {15'd0, tc}, 16'd1);
      idleCycles(4);
    end
    checkOutput("tcOnce", 16'(tcSeen - tcBase), 16'd1);
    checkOutput("expiredHeld", {15'd0, expired}, 16'd1);

    // Digit clamp then minute clamp.
    applyStimulus(0, 1, 8'h7F, 8'h6A, 0, 0, 0);
    checkOutput("clamp5959", {min_q, sec_q}, 16'h5959);

    // Pause holds the count even with ticks, start resumes.
    applyStimulus(0, 1, 8'h00, 8'h03, 0, 0, 0);
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 0, 0);
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 8'h00, 8'h00, 0, 1, 1);
    checkOutput("pauseHold", {min_q, sec_q}, 16'h0002);
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 0, 0);
    checkOutput("resumed", {15'd0, running}, 16'd1);
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 1);
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 1);
    checkOutput("pauseDoneTc", {15'd0, tc}, 16'd1);

    // Restart from reload register, then zero reload pulses tc repeatedly.
    applyStimulus(0, 1, 8'h00, 8'h02, 0, 0, 0);
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 0, 0);
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 1);
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 1);
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 0, 0);
    checkOutput("reload0002", {min_q, sec_q}, 16'h0002);
    checkOutput("reloadNoTc", {14'd0, running, tc}, 16'h0002);
    applyStimulus(0, 1, 8'h00, 8'h00, 0, 0, 0);
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 0, 0);
    checkOutput("zeroStartTc", {14'd0, expired, tc}, 16'h0003);
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 0);
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 0, 0);
    checkOutput("zeroRestartTc", {15'd0, tc}, 16'd1);

    // Load during RUN at 00:01 with a tick: load wins, no decrement, no tc.
    applyStimulus(0, 1, 8'h00, 8'h02, 0, 0, 0);
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 0, 0);
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 1);
    applyStimulus(0, 1, 8'h00, 8'h45, 0, 0, 1);
    checkOutput("ldOverTick", {min_q, sec_q}, 16'h0045);
    checkOutput("ldOverTickFlags", {13'd0, running, expired, tc}, 16'h0000);

    // Randomized traffic biased toward short countdowns.
    for (int i = 0; i < 3000; i++) begin
      rnd = $urandom;
      rdm = rnd[7:0];
      rds = rnd[15:8];
      if (rnd[16]) rdm = 8'h00;
      if (rnd[17]) rds = {4'd0, rnd[11:8]};
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0, rdm, rds,
                    $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 2) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
